mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-port instruction/data memory between the CPU instruction-fetch port (IF) and the data-memory port (DM) of the minimal SOPC.
- Sequences each access through a request/ready handshake and holds the granted requester until the memory responds.
- Raises a pipeline stall request while any access is pending.
- Aborts with an error flag if the memory never responds.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byte-select width is DATA_W/8.
- TIMEOUT, 16, number of wait cycles in a grant state before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request (read only).
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data access request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_sel  in  DATA_W/8  byte enables.
- dm_rdata  out  DATA_W  data read result; valid while dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for DM.
- mem_ce  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_sel  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data; valid when mem_rdy=1.
- mem_rdy  in  1  memory completion; sampled only while mem_ce=1.
- stall_req  out  1  pipeline stall request to the ctrl block.
- timeout_err  out  1  sticky error flag; set on timeout abort.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=IF, wait counter=0, timeout_err=0, and all registered outputs = 0 (mem_ce, mem_we, mem_addr, mem_wdata, mem_sel, if_ack, dm_ack, if_rdata, dm_rdata).
- Reset mid-access drops mem_ce immediately; no ack is issued for the aborted access.
- FSM states: IDLE, GNT_IF, GNT_DM.
- IDLE arbitration, evaluated at each edge:
  - dm_req only: go to GNT_DM.
  - if_req only: go to GNT_IF.
  - Both requesting: go to GNT_IF if last_grant=DM, else GNT_DM. The result is round-robin under contention, with DM winning the first contention after reset.
  - On entering a grant state, register mem_ce=1 plus the address, data, sel and we of the winner; update last_grant; clear the wait counter.
  - IF accesses drive mem_we=0 and mem_sel all ones.
- GNT_x with mem_rdy=1 at an edge:
  - Capture mem_rdata into x_rdata (DM writes capture 0).
  - Pulse x_ack=1 for exactly one cycle.
  - Clear mem_ce, mem_we and mem_sel.
  - Return to IDLE.
- GNT_x with mem_rdy=0: increment the wait counter. When the counter reaches TIMEOUT-1 and mem_rdy is still 0:
  - Abort: x_ack=1 with x_rdata=0, set timeout_err=1, return to IDLE.
  - timeout_err stays set until reset.
  - mem_rdy arriving on the same edge as timeout is a normal completion, not a timeout.
- Latency with a zero-wait memory (mem_rdy tied high):
  - Request sampled at edge k.
  - mem_ce high after edge k+1.
  - ack high after edge k+2.
  - The next request is sampled at edge k+3.
  - Each memory wait cycle adds one cycle.
- Requester rules:
  - req and its payload must stay stable from assertion until ack.
  - req still high at the edge that ends the ack cycle is treated as a new request.
  - The requester drops req combinationally on ack to avoid a duplicate access.
  - Payload changes while granted are ignored; values are latched at grant.
- stall_req is combinational: (if_req & ~if_ack) | (dm_req & ~dm_ack).
- if_ack and dm_ack are never high in the same cycle.
- mem_ce never drops in the middle of an access except on completion, abort or reset.

Test Plan:
- Zero-wait IF read: mem_rdy=1, if_addr=0x00000010, mem_rdata=0x3401FFFF, req at edge k → mem_ce=1 with mem_addr=0x10 after k+1; if_ack=1 and if_rdata=0x3401FFFF after k+2, one cycle only; stall_req=1 until the ack cycle.
- DM byte write with 2 wait states: dm_we=1, dm_addr=0x40, dm_wdata=0xAABBCCDD, dm_sel=4'b0010 → mem_we=1 and mem_sel=0010 held for 3 cycles; dm_ack one cycle after mem_rdy; mem_ce=0 afterwards.
- Contention: if_req and dm_req held continuously after reset → grant order DM, IF, DM, IF; acks alternate and never overlap.
- Timeout: TIMEOUT=4, mem_rdy=0, if_req → after 4 grant cycles if_ack=1, if_rdata=0, timeout_err=1, held across later successful accesses; mem_rdy on the 4th cycle instead gives a normal ack and timeout_err=0.
- Reset mid-access: assert rst=0 during GNT_DM wait → mem_ce, dm_ack and stall-related state cleared immediately, no ack after release; the first contention after release grants DM.
- Back-to-back DM reads with req held through ack: two accesses occur, 3 cycles apart with a zero-wait memory, each with its own ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the CPU instruction-fetch port (IF)
//   and the data-memory port (DM). Each access runs IDLE -> GNT_x (launch
//   cycle) -> GNT_x (memory cycles, mem_ce=1) -> IDLE with a one-cycle ack.
//   Contention is resolved round-robin; DM wins the first contention after
//   reset. An access that sees no mem_rdy for TIMEOUT memory cycles is
//   aborted with a zero-data ack and a sticky timeout_err.
//
// Handshake (both requester ports):
//   x_req and its payload are held stable from assertion until x_ack. x_ack
//   is a single-cycle pulse; x_rdata is valid while x_ack=1. A req still high
//   at the edge that ends the ack cycle starts a new access, so a requester
//   that wants one access drops req combinationally on ack. The memory side
//   completes an access by raising mem_rdy while mem_ce=1; mem_rdy is ignored
//   whenever mem_ce=0.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   if_req/if_addr     fetch request (read only) -> if_rdata, if_ack
//   dm_req/dm_we/dm_addr/dm_wdata/dm_sel -> dm_rdata, dm_ack
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_sel, mem_rdata/mem_rdy  memory side
//   stall_req          combinational pipeline stall request
//   timeout_err        sticky abort flag, cleared only by reset
//   fsm_state          current FSM state (0=IDLE, 1=GNT_IF, 2=GNT_DM)

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_sel,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_sel,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rdy,
  output logic                stall_req,
  output logic                timeout_err,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } state_t;

  // Last memory cycle index before an access is aborted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_dm;   // 1 when the most recent grant went to DM
  logic [7:0] wait_cnt;

  assign fsm_state = state;
  assign stall_req = (if_req & ~if_ack) | (dm_req & ~dm_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_dm     <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      mem_ce      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_sel     <= '0;
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          // DM wins contention unless it was granted last.
          if (dm_req && (!if_req || !last_dm)) begin
            state    <= GNT_DM;
            last_dm  <= 1'b1;
            wait_cnt <= '0;
          end else if (if_req) begin
            state    <= GNT_IF;
            last_dm  <= 1'b0;
            wait_cnt <= '0;
          end
        end
        GNT_IF, GNT_DM: begin
          if (!mem_ce) begin
            // Launch cycle: latch the winner's payload onto the memory bus.
            mem_ce <= 1'b1;
            if (state == GNT_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_sel   <= dm_sel;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_sel   <= '1;
            end
          end else if (mem_rdy || (wait_cnt == WAIT_LAST)) begin
            // Completion or abort; a late mem_rdy on the last cycle still
            // counts as a normal completion.
            state   <= IDLE;
            mem_ce  <= 1'b0;
            mem_we  <= 1'b0;
            mem_sel <= '0;
            if (!mem_rdy) timeout_err <= 1'b1;
            if (state == GNT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdy ? mem_rdata : '0;
            end else begin
              dm_ack   <= 1'b1;
              dm_rdata <= (mem_rdy && !mem_we) ? mem_rdata : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (TIMEOUT=4). A behavioural memory
//   raises mem_rdy after a programmable number of wait cycles. Stimulus pushes
//   expected acks ({port, rdata}) and expected memory launches
//   ({we, sel, addr, wdata}) into queues; a monitor pops and compares them
//   whenever an ack pulses or mem_ce rises.

module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int GW = 1 + SW + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [SW-1:0] dm_sel;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_sel;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;
  logic          stall_req;
  logic          timeout_err;
  logic [1:0]    fsm_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_sel(dm_sel), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_rdy(mem_rdy), .stall_req(stall_req), .timeout_err(timeout_err),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW:0]   exp_q[$];   // {port (1=DM), rdata}
  logic [GW-1:0] gnt_q[$];   // {we, sel, addr, wdata}
  int            wait_states = 0;
  logic [DW-1:0] mem_data    = '0;
  int            wcnt        = 0;
  logic          prev_ce     = 1'b0;

  task automatic check(input string name, input logic [GW-1:0] act,
                       input logic [GW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic dm, input logic [DW-1:0] data);
    exp_q.push_back({dm, data});
  endtask

  task automatic push_gnt(input logic we, input logic [SW-1:0] sel,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    gnt_q.push_back({we, sel, addr, wdata});
  endtask

  // Wait for an ack on the chosen port; cyc = negedges elapsed.
  task automatic wait_ack(input logic dm, input int bound, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (dm ? dm_ack : if_ack) break;
      if (cyc >= bound) begin
        vectors++;
        miscompares++;
        $display("FAIL ack_wait: no %s ack after %0d cycles, required an ack",
                 dm ? "DM" : "IF", cyc);
        break;
      end
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    mem_rdy   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ce) begin
        mem_rdy = (wcnt == wait_states);
        wcnt++;
      end else begin
        mem_rdy = 1'b0;
        wcnt    = 0;
      end
      mem_rdata = mem_data;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [DW:0]   e;
    logic [GW-1:0] g;
    forever begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        check("ack_exclusive", GW'(if_ack & dm_ack), GW'(0));
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b, required none",
                   if_ack, dm_ack);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", GW'(dm_ack), GW'(e[DW]));
          check("ack_rdata", GW'(dm_ack ? dm_rdata : if_rdata), GW'(e[DW-1:0]));
        end
      end
      if (mem_ce && !prev_ce) begin
        if (gnt_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_access: addr=0x%0h, required no access", mem_addr);
        end else begin
          g = gnt_q.pop_front();
          check("mem_launch", {mem_we, mem_sel, mem_addr, mem_wdata}, g);
        end
      end
      prev_ce = mem_ce;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int held;
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_sel = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", GW'({mem_ce, mem_we, mem_sel, if_ack, dm_ack,
                              timeout_err, fsm_state}), GW'(0));
    check("reset_bus", GW'({mem_addr, mem_wdata}), GW'(0));
    check("reset_rdata", GW'({if_rdata, dm_rdata}), GW'(0));
    rst = 1'b1;
    @(negedge clk);

    // Contention after reset: DM, IF, DM, IF with both reqs held.
    wait_states = 0; mem_data = 32'h1111_2222;
    dm_we = 1'b0; dm_addr = 32'h100; dm_sel = 4'hF; dm_wdata = '0;
    if_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        push_gnt(1'b0, 4'hF, 32'h100, '0); push_exp(1'b1, 32'h1111_2222);
      end else begin
        push_gnt(1'b0, 4'hF, 32'h200, '0); push_exp(1'b0, 32'h1111_2222);
      end
    end
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack((i % 2) == 0, 10, cyc);
      check("contention_spacing", GW'(cyc), GW'(3));
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);

    // Zero-wait IF read, cycle-exact.
    mem_data = 32'h3401_FFFF; if_addr = 32'h10;
    push_gnt(1'b0, 4'hF, 32'h10, '0); push_exp(1'b0, 32'h3401_FFFF);
    if_req = 1'b1;
    #1 check("if_stall_on_req", GW'(stall_req), GW'(1));
    @(negedge clk);
    check("if_launch_cycle", GW'({mem_ce, fsm_state}), GW'({1'b0, 2'd1}));
    @(negedge clk);
    check("if_mem_cycle", GW'({mem_ce, mem_addr, if_ack, stall_req}),
          GW'({1'b1, 32'h10, 1'b0, 1'b1}));
    @(negedge clk);
    check("if_ack_cycle", GW'({if_ack, if_rdata, stall_req, mem_ce}),
          GW'({1'b1, 32'h3401_FFFF, 1'b0, 1'b0}));
    if_req = 1'b0;
    @(negedge clk);
    check("if_ack_single", GW'(if_ack), GW'(0));

    // DM byte write with two wait states.
    wait_states = 2; mem_data = 32'h5555_6666;
    dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hAABB_CCDD; dm_sel = 4'b0010;
    push_gnt(1'b1, 4'b0010, 32'h40, 32'hAABB_CCDD); push_exp(1'b1, '0);
    dm_req = 1'b1;
    held = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_ce && mem_we && mem_sel == 4'b0010) held++;
    end while (!dm_ack && cyc < 20);
    dm_req = 1'b0; dm_we = 1'b0;
    check("write_hold_cycles", GW'(held), GW'(3));
    check("write_latency", GW'(cyc), GW'(5));
    @(negedge clk);
    check("write_bus_released", GW'({mem_ce, mem_we, mem_sel}), GW'(0));

    // Back-to-back DM reads with req held through the first ack.
    wait_states = 0; mem_data = 32'h1234_5678;
    dm_addr = 32'h80; dm_sel = 4'hF; dm_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      push_gnt(1'b0, 4'hF, 32'h80, '0); push_exp(1'b1, 32'h1234_5678);
    end
    dm_req = 1'b1;
    wait_ack(1'b1, 10, cyc);
    check("b2b_first_latency", GW'(cyc), GW'(3));
    wait_ack(1'b1, 10, cyc);
    check("b2b_spacing", GW'(cyc), GW'(3));
    dm_req = 1'b0;
    @(negedge clk);

    // Timeout abort on a dead memory.
    wait_states = 1000; if_addr = 32'h20;
    push_gnt(1'b0, 4'hF, 32'h20, '0); push_exp(1'b0, '0);
    if_req = 1'b1;
    wait_ack(1'b0, 20, cyc);
    if_req = 1'b0;
    check("timeout_latency", GW'(cyc), GW'(6));
    check("timeout_err_set", GW'(timeout_err), GW'(1));
    @(negedge clk);

    // A later good access leaves timeout_err set.
    wait_states = 0; mem_data = 32'hCAFE_0001; if_addr = 32'h24;
    push_gnt(1'b0, 4'hF, 32'h24, '0); push_exp(1'b0, 32'hCAFE_0001);
    if_req = 1'b1;
    wait_ack(1'b0, 10, cyc);
    if_req = 1'b0;
    check("timeout_err_sticky", GW'(timeout_err), GW'(1));
    @(negedge clk);

    // Reset in the middle of a DM wait.
    wait_states = 1000; dm_we = 1'b0; dm_addr = 32'h300;
    push_gnt(1'b0, 4'hF, 32'h300, '0);
    dm_req = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_pre_ce", GW'(mem_ce), GW'(1));
    rst = 1'b0; dm_req = 1'b0;
    #1 check("midreset_cleared", GW'({mem_ce, dm_ack, stall_req, timeout_err,
                                      fsm_state}), GW'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_idle", GW'({mem_ce, fsm_state}), GW'(0));

    // First contention after release goes to DM.
    wait_states = 0; mem_data = 32'h0BAD_F00D;
    dm_addr = 32'h400; if_addr = 32'h500;
    push_gnt(1'b0, 4'hF, 32'h400, '0); push_exp(1'b1, 32'h0BAD_F00D);
    push_gnt(1'b0, 4'hF, 32'h500, '0); push_exp(1'b0, 32'h0BAD_F00D);
    if_req = 1'b1; dm_req = 1'b1;
    wait_ack(1'b1, 10, cyc);
    dm_req = 1'b0;
    wait_ack(1'b0, 10, cyc);
    if_req = 1'b0;
    @(negedge clk);

    // mem_rdy on the last allowed cycle is a normal completion.
    wait_states = 3; mem_data = 32'h7777_8888; if_addr = 32'h30;
    push_gnt(1'b0, 4'hF, 32'h30, '0); push_exp(1'b0, 32'h7777_8888);
    if_req = 1'b1;
    wait_ack(1'b0, 20, cyc);
    if_req = 1'b0;
    check("late_rdy_latency", GW'(cyc), GW'(6));
    check("late_rdy_no_err", GW'(timeout_err), GW'(0));

    repeat (3) @(negedge clk);
    check("exp_q_drained", GW'(exp_q.size()), GW'(0));
    check("gnt_q_drained", GW'(gnt_q.size()), GW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
